// File: rtl/logic_gates_sweeper_if.sv
// ---------------------------------------------------------------------------
// logic_gates_sweeper_if
//
// Bundles the sweep control/status and the gate-block operand/result signals
// shared between the self-test sequencer and whoever hosts it.
//
//   start      sweep request                         (host -> sweeper)
//   res_in     7 gate results from the gate block    (host -> sweeper)
//              bit0 AND, bit1 NAND, bit2 OR, bit3 NOR, bit4 NOT(A),
//              bit5 XOR, bit6 XNOR
//   op_a/op_b  registered operands to the gate block (sweeper -> host)
//   busy       sweep in progress                     (sweeper -> host)
//   done       one-cycle end-of-sweep pulse          (sweeper -> host)
//   pass       last completed sweep had no mismatch  (sweeper -> host)
//   err_count  mismatching vector checks, saturating (sweeper -> host)
//   fail_vec   per-vector failure flags              (sweeper -> host)
//   fail_mask  per-gate failure flags                (sweeper -> host)
//
// Modports: master = host / gate-block side, slave = the sweeper itself.
// ---------------------------------------------------------------------------
interface logic_gates_sweeper_if;
  logic       start;
  logic [6:0] res_in;
  logic       op_a;
  logic       op_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [3:0] fail_vec;
  logic [6:0] fail_mask;

  modport master (
    output start,
    output res_in,
    input  op_a,
    input  op_b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec,
    input  fail_mask
  );

  modport slave (
    input  start,
    input  res_in,
    output op_a,
    output op_b,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec,
    output fail_mask
  );
endinterface

// File: rtl/logic_gates_sweeper.sv
// ---------------------------------------------------------------------------
// logic_gates_sweeper
//
// Self-test sequencer wrapped around one 2-input logic-gate block. A sweep
// walks the operands through 00, 01, 10, 11 (NUM_PASSES times), holds each
// pair for SETTLE_CYCLES cycles, then compares the seven gate results against
// the golden truth table and accumulates per-vector and per-gate failures.
//
// Parameters
//   SETTLE_CYCLES  cycles operands are stable before sampling (1..15)
//   NUM_PASSES     complete 4-vector sweeps per start         (1..63)
//
// Ports
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    logic_gates_sweeper_if.slave (start, res_in in; operands and
//          sweep status/results out)
//
// Every vector costs SETTLE_CYCLES+2 clock edges (DRIVE, SETTLE x S, CHECK);
// done pulses in the cycle after the last CHECK edge.
// ---------------------------------------------------------------------------
module logic_gates_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_gates_sweeper_if.slave bus
);

  // Elaboration-time guard on the legal parameter ranges.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("logic_gates_sweeper: SETTLE_CYCLES must be in 1..15");
  end
  if (NUM_PASSES < 1 || NUM_PASSES > 63) begin : g_bad_passes
    $error("logic_gates_sweeper: NUM_PASSES must be in 1..63");
  end

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [5:0] LAST_PASS   = 6'(NUM_PASSES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Expected gate outputs for a given operand pair, in res_in bit order.
  function automatic logic [6:0] golden_of(input logic a, input logic b);
    return {~(a ^ b), (a ^ b), ~a, ~(a | b), (a | b), ~(a & b), (a & b)};
  endfunction

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  state_t     state_q,      state_d;
  logic       op_a_q,       op_a_d;
  logic       op_b_q,       op_b_d;
  logic [1:0] vec_q,        vec_d;
  logic [5:0] pass_cnt_q,   pass_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] err_count_q,  err_count_d;
  logic [3:0] fail_vec_q,   fail_vec_d;
  logic [6:0] fail_mask_q,  fail_mask_d;
  logic       pass_q,       pass_d;

  logic [6:0] golden;
  logic [6:0] diff;

  // Golden is derived from the registered operands actually presented to the
  // gate block, so a stuck operand register shows up as a gate mismatch
  // only if the block disagrees with what we think we drove.
  assign golden = golden_of(op_a_q, op_b_q);
  assign diff   = bus.res_in ^ golden;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= 1'b0;
      op_b_q       <= 1'b0;
      vec_q        <= 2'd0;
      pass_cnt_q   <= 6'd0;
      settle_cnt_q <= 4'd0;
      err_count_q  <= 8'd0;
      fail_vec_q   <= 4'd0;
      fail_mask_q  <= 7'd0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_count_q  <= err_count_d;
      fail_vec_q   <= fail_vec_d;
      fail_mask_q  <= fail_mask_d;
      pass_q       <= pass_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_count_d  = err_count_q;
    fail_vec_d   = fail_vec_q;
    fail_mask_d  = fail_mask_q;
    pass_d       = pass_q;

    unique case (state_q)
      IDLE: begin
        op_a_d = 1'b0;
        op_b_d = 1'b0;
        if (bus.start) begin
          err_count_d = 8'd0;
          fail_vec_d  = 4'd0;
          fail_mask_d = 7'd0;
          pass_d      = 1'b0;
          vec_d       = 2'd0;
          pass_cnt_d  = 6'd0;
          state_d     = DRIVE;
        end
      end

      DRIVE: begin
        op_a_d       = vec_q[1];
        op_b_d       = vec_q[0];
        settle_cnt_d = SETTLE_INIT;
        state_d      = SETTLE;
      end

      SETTLE: begin
        // The cycle holding a count of 1 is the last settle cycle, which
        // keeps the operands stable for exactly SETTLE_CYCLES cycles.
        settle_cnt_d = settle_cnt_q - 4'd1;
        if (settle_cnt_q <= 4'd1) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (diff != 7'd0) begin
          err_count_d        = sat_inc(err_count_q);
          fail_vec_d[vec_q]  = 1'b1;
          fail_mask_d        = fail_mask_q | diff;
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = DRIVE;
        end else if (pass_cnt_q < LAST_PASS) begin
          pass_cnt_d = pass_cnt_q + 6'd1;
          vec_d      = 2'd0;
          state_d    = DRIVE;
        end else begin
          // Verdict is taken from the count including this final check so
          // that pass is already valid while done is high.
          pass_d  = (err_count_d == 8'd0);
          state_d = DONE;
        end
      end

      DONE: begin
        // Operands return to 00 together with the return to IDLE.
        op_a_d  = 1'b0;
        op_b_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_mask = fail_mask_q;

endmodule
